// File: rtl/beam_power_scheduler_pkg.sv
// ============================================================================
// Module  : beam_power_scheduler_pkg
// Brief   : Shared types and width helpers for the beam power scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package beam_power_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  // Exact worst-case width of one clock's slot sum.
  function automatic int slot_sum_bits(input int outbits, input int demux);
    return outbits + $clog2(demux);
  endfunction

  function automatic int acc_bits(input int outbits, input int demux, input int window);
    return slot_sum_bits(outbits, demux) + $clog2(window);
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Shared flush/window counter must hold the larger of the two loads.
  function automatic int cnt_bits(input int pipe_lat, input int window);
    int m;
    m = (pipe_lat + 1 > window) ? pipe_lat + 1 : window;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/beam_power_scheduler_power_sum_tree.sv
// ============================================================================
// Module  : power_sum_tree
// Brief   : Sums DEMUX squared slots per clock into one registered word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module power_sum_tree
  import beam_power_scheduler_pkg::*;
#(
  parameter int   DEMUX   = 16,
  parameter int   OUTBITS = 6,
  localparam int  SUMBITS = slot_sum_bits(OUTBITS, DEMUX)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [OUTBITS*DEMUX-1:0]   sq_in,
  output logic [SUMBITS-1:0]         sum_out
);

  logic [SUMBITS-1:0] sum_d;
  logic [SUMBITS-1:0] sum_q;

  // Linear reduction; synthesis rebalances it into a tree.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < DEMUX; i++) begin
      sum_d = sum_d + SUMBITS'(sq_in[i*OUTBITS +: OUTBITS]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_out = sum_q;

endmodule

`default_nettype wire

// File: rtl/beam_power_scheduler.sv
// ============================================================================
// Module  : beam_power_scheduler
// Brief   : Sweeps beam delays, flushes the datapath, accumulates power and
//           hands one result per beam downstream over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module beam_power_scheduler
  import beam_power_scheduler_pkg::*;
#(
  parameter int   DEMUX    = 16,
  parameter int   OUTBITS  = 6,
  parameter int   NBEAMS   = 8,
  parameter int   PIPE_LAT = 2,
  parameter int   WINDOW   = 4,
  localparam int  ACCBITS  = acc_bits(OUTBITS, DEMUX, WINDOW),
  localparam int  BEAMBITS = idx_bits(NBEAMS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [OUTBITS*DEMUX-1:0]  sq_in,
  output logic [BEAMBITS-1:0]       beam_sel,
  output logic [ACCBITS-1:0]        pwr_out,
  output logic [BEAMBITS-1:0]       pwr_beam,
  output logic                      pwr_valid,
  input  logic                      pwr_ready,
  output logic                      busy,
  output logic                      sweep_done
);

  localparam int                   SUMBITS    = slot_sum_bits(OUTBITS, DEMUX);
  localparam int                   CNTBITS    = cnt_bits(PIPE_LAT, WINDOW);
  localparam logic [CNTBITS-1:0]   FLUSH_LOAD = CNTBITS'(PIPE_LAT + 1);
  localparam logic [CNTBITS-1:0]   ACCUM_LOAD = CNTBITS'(WINDOW - 1);
  localparam logic [CNTBITS-1:0]   CNT_ONE    = CNTBITS'(1);
  localparam logic [BEAMBITS-1:0]  LAST_BEAM  = BEAMBITS'(NBEAMS - 1);

  state_t                state_q, state_d;
  logic [BEAMBITS-1:0]   beam_idx_q, beam_idx_d;
  logic [BEAMBITS-1:0]   beam_sel_q, beam_sel_d;
  logic [BEAMBITS-1:0]   pwr_beam_q, pwr_beam_d;
  logic [CNTBITS-1:0]    cnt_q, cnt_d;
  logic [ACCBITS-1:0]    acc_q, acc_d;
  logic                  sweep_done_q, sweep_done_d;
  logic [SUMBITS-1:0]    slot_sum;

  power_sum_tree #(
    .DEMUX   (DEMUX),
    .OUTBITS (OUTBITS)
  ) u_sum_tree (
    .clk     (clk),
    .rst     (rst),
    .sq_in   (sq_in),
    .sum_out (slot_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; enable is only consulted at beam boundaries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_SELECT;
      ST_SELECT: state_d = ST_FLUSH;
      ST_FLUSH:  if (cnt_q == CNT_ONE) state_d = ST_ACCUM;
      ST_ACCUM:  if (cnt_q == '0) state_d = ST_REPORT;
      ST_REPORT: if (pwr_ready) state_d = enable ? ST_SELECT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = (state_q != ST_IDLE);
    pwr_valid = (state_q == ST_REPORT);
  end

  // Datapath next values
  always_comb begin
    beam_idx_d   = beam_idx_q;
    beam_sel_d   = beam_sel_q;
    pwr_beam_d   = pwr_beam_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    sweep_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        beam_sel_d = '0;
      end
      ST_SELECT: begin
        beam_sel_d = beam_idx_q;
        acc_d      = '0;
        cnt_d      = FLUSH_LOAD;
      end
      ST_FLUSH: begin
        // The last flush cycle reloads the counter for the window.
        cnt_d = (cnt_q == CNT_ONE) ? ACCUM_LOAD : cnt_q - CNT_ONE;
      end
      ST_ACCUM: begin
        acc_d = acc_q + ACCBITS'(slot_sum);
        if (cnt_q == '0) begin
          pwr_beam_d = beam_idx_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_REPORT: begin
        if (pwr_ready) begin
          beam_idx_d   = (beam_idx_q == LAST_BEAM) ? '0 : beam_idx_q + 1'b1;
          sweep_done_d = (beam_idx_q == LAST_BEAM);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beam_idx_q   <= '0;
      beam_sel_q   <= '0;
      pwr_beam_q   <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      beam_idx_q   <= beam_idx_d;
      beam_sel_q   <= beam_sel_d;
      pwr_beam_q   <= pwr_beam_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign beam_sel   = beam_sel_q;
  assign pwr_out    = acc_q;
  assign pwr_beam   = pwr_beam_q;
  assign sweep_done = sweep_done_q;

endmodule

`default_nettype wire

// File: tb/tb_beam_power_scheduler.sv
// ============================================================================
// Module  : tb_beam_power_scheduler
// Brief   : Scoreboard bench for beam_power_scheduler with a PIPE_LAT-delayed
//           datapath model driving sq_in.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beam_power_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [95:0] sq_in;
  logic [2:0]  beam_sel;
  logic [11:0] pwr_out;
  logic [2:0]  pwr_beam;
  logic        pwr_valid;
  logic        pwr_ready;
  logic        busy;
  logic        sweep_done;

  beam_power_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sq_in      (sq_in),
    .beam_sel   (beam_sel),
    .pwr_out    (pwr_out),
    .pwr_beam   (pwr_beam),
    .pwr_valid  (pwr_valid),
    .pwr_ready  (pwr_ready),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  // Datapath model: sq_in reflects beam_sel from two clocks earlier.
  int         mode;
  logic [5:0] const_val;
  logic [2:0] bs_d1 = '0;
  logic [2:0] bs_d2 = '0;

  always @(posedge clk) begin
    bs_d1 <= beam_sel;
    bs_d2 <= bs_d1;
  end

  always_comb begin
    sq_in = '0;
    for (int i = 0; i < 16; i++) begin
      sq_in[i*6 +: 6] = (mode == 1) ? 6'(bs_d2) + 6'd1 : const_val;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  beam;
    logic [11:0] pwr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc       = 0;
  int   last_hs   = -1;
  bit   gap_check = 1'b0;
  logic exp_sd    = 1'b0;

  // Monitor: checks sweep_done every cycle and every accepted result.
  always @(negedge clk) begin
    cyc++;
    check("sweep_done", {31'd0, sweep_done}, {31'd0, exp_sd});
    exp_sd = 1'b0;
    if (!rst && pwr_valid && pwr_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pwr_beam", {29'd0, pwr_beam}, {29'd0, mon_e.beam});
        check("pwr_out", {20'd0, pwr_out}, {20'd0, mon_e.pwr});
      end
      if (gap_check && last_hs >= 0) begin
        check("result_gap", cyc - last_hs, 32'd9);
      end
      last_hs = cyc;
      exp_sd  = (pwr_beam == 3'd7);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic push(input int beam, input int pwr);
    exp_t e;
    e.beam = 3'(beam);
    e.pwr  = 12'(pwr);
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int target, input string name);
    int n = 0;
    while (sb.size() > target && n < 400) begin
      tick;
      n++;
    end
    check(name, {31'd0, sb.size() <= target}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick;
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!pwr_valid && n < 100) begin
      tick;
      n++;
    end
    check(name, {31'd0, pwr_valid}, 32'd1);
  endtask

  // Called just after the reset edge has been applied.
  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_beam_sel"},   {29'd0, beam_sel},   32'd0);
    check({tag, "_pwr_out"},    {20'd0, pwr_out},    32'd0);
    check({tag, "_pwr_beam"},   {29'd0, pwr_beam},   32'd0);
    check({tag, "_pwr_valid"},  {31'd0, pwr_valid},  32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_sweep_done"}, {31'd0, sweep_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b1;
    enable    = 1'b0;
    pwr_ready = 1'b1;
    mode      = 0;
    const_val = 6'd1;
    tick;
    tick;
    check_reset_outputs("reset");
    tick;
    rst = 1'b0;

    // Constant 1 sweep: eight beams of 64, 9 cycles apart, then one more.
    for (int k = 0; k < 9; k++) push(k % 8, 64);
    gap_check = 1'b1;
    last_hs   = -1;
    enable    = 1'b1;
    wait_sb(1, "sweep1_progress");
    enable = 1'b0;
    wait_sb(0, "sweep1_done");
    wait_idle("sweep1_idle");
    gap_check = 1'b0;

    // Full scale with a 20-cycle stall; sq_in changes during the stall.
    do_reset;
    const_val = 6'd63;
    pwr_ready = 1'b0;
    enable    = 1'b1;
    tick;
    enable = 1'b0;
    wait_valid("stall_valid");
    const_val = 6'd5;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("stall_valid_hold", {31'd0, pwr_valid}, 32'd1);
      check("stall_pwr_out",    {20'd0, pwr_out},   32'd4032);
      check("stall_pwr_beam",   {29'd0, pwr_beam},  32'd0);
      check("stall_beam_sel",   {29'd0, beam_sel},  32'd0);
      tick;
    end
    push(0, 4032);
    pwr_ready = 1'b1;
    wait_sb(0, "stall_release");
    wait_idle("stall_idle");

    // Beam-dependent data; enable dropped during ACCUM of beam 3.
    do_reset;
    mode = 1;
    for (int k = 0; k < 4; k++) push(k, 64 * (k + 1));
    enable = 1'b1;
    n = 0;
    while (beam_sel != 3'd3 && n < 200) begin
      tick;
      n++;
    end
    check("reach_beam3", {29'd0, beam_sel}, 32'd3);
    tick;
    tick;
    tick;
    tick;
    enable = 1'b0;
    wait_sb(0, "beams0_3");
    wait_idle("pause_idle");
    tick;
    tick;
    tick;
    check("pause_busy", {31'd0, busy}, 32'd0);
    check("pause_beam_sel", {29'd0, beam_sel}, 32'd0);
    for (int k = 4; k < 8; k++) push(k, 64 * (k + 1));
    push(0, 64);
    enable = 1'b1;
    wait_sb(1, "beams4_7");
    enable = 1'b0;
    wait_sb(0, "beams_wrap");
    wait_idle("beams_idle");

    // Reset during FLUSH and during REPORT; sweep restarts at beam 0.
    do_reset;
    mode      = 0;
    const_val = 6'd1;
    pwr_ready = 1'b0;
    enable    = 1'b1;
    tick;
    tick;
    rst = 1'b1;
    @(posedge clk);
    check_reset_outputs("rst_flush");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_valid("rst_report_valid");
    rst = 1'b1;
    @(posedge clk);
    check_reset_outputs("rst_report");
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(0, 64);
    push(1, 64);
    push(2, 64);
    pwr_ready = 1'b1;
    wait_sb(1, "post_rst_progress");
    enable = 1'b0;
    wait_sb(0, "post_rst_done");
    wait_idle("post_rst_idle");

    tick;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
